// File: rtl/system.sv
// FSMC (NE1, 16-bit async) to single 16-bit SDR SDRAM bridge: init sequencer, auto-refresh,
// single-word read/write engine and init-done LED.
module system #(
  parameter int unsigned INIT_CYCLES    = 5000,
  parameter int unsigned REFRESH_CYCLES = 390,
  parameter int unsigned T_RP           = 2,
  parameter int unsigned T_RC           = 4,
  parameter int unsigned T_RCD          = 2,
  parameter int unsigned T_MRD          = 2,
  parameter int unsigned T_WRAP         = 4,
  parameter int unsigned CAS_LAT        = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        led,
  input  logic [15:0] fsmc_a,
  inout  wire  [15:0] fsmc_d,
  input  logic        fsmc_ne1,
  input  logic        fsmc_nwe,
  input  logic        fsmc_noe,
  input  logic        fsmc_nbl1,
  input  logic        fsmc_nbl0,
  output logic        sdr_clk,
  output logic        sdr_cke,
  output logic        sdr_cs_n,
  output logic        sdr_ras_n,
  output logic        sdr_cas_n,
  output logic        sdr_we_n,
  output logic [1:0]  sdr_ba,
  output logic [11:0] sdr_a,
  output logic [1:0]  sdr_dm,
  inout  wire  [15:0] sdr_dq
);

  localparam logic [3:0] CmdNop  = 4'b0111;
  localparam logic [3:0] CmdAct  = 4'b0011;
  localparam logic [3:0] CmdRead = 4'b0101;
  localparam logic [3:0] CmdWrit = 4'b0100;
  localparam logic [3:0] CmdPre  = 4'b0010;
  localparam logic [3:0] CmdRef  = 4'b0001;
  localparam logic [3:0] CmdLmr  = 4'b0000;

  localparam logic [3:0] StInitWait = 4'd0;
  localparam logic [3:0] StInitPre  = 4'd1;
  localparam logic [3:0] StInitRef1 = 4'd2;
  localparam logic [3:0] StInitRef2 = 4'd3;
  localparam logic [3:0] StInitMrs  = 4'd4;
  localparam logic [3:0] StWait     = 4'd5;
  localparam logic [3:0] StIdle     = 4'd6;
  localparam logic [3:0] StWr       = 4'd7;
  localparam logic [3:0] StRd       = 4'd8;
  localparam logic [3:0] StRdCap    = 4'd9;

  logic [3:0]  st_q, st_d, ret_q, ret_d;
  logic [15:0] cnt_q, cnt_d, ref_cnt_q, ref_cnt_d;
  logic        ref_pend_q, ref_pend_d, wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic        ref_clr, wr_clr, rd_clr;
  logic [15:0] wr_addr_q, wr_data_q, rd_addr_q;
  logic [15:0] op_addr_q, op_addr_d, op_data_q, op_data_d;
  logic [15:0] rdata_q, rdata_d, dq_out_q, dq_out_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [11:0] a_q, a_d;
  logic        dq_oe_q, dq_oe_d, led_q, led_d;
  // Synchroniser bits: [2]=ne1, [1]=nwe, [0]=noe
  logic [2:0]  sync1_q, sync2_q;
  logic        wr_cond, rd_cond, wr_cond_q, rd_cond_q, wr_rise, rd_rise;
  logic        unused_nbl;

  assign unused_nbl = fsmc_nbl1 ^ fsmc_nbl0;

  assign wr_cond = ~sync2_q[2] & ~sync2_q[1];
  assign rd_cond = ~sync2_q[2] & ~sync2_q[0];
  assign wr_rise = wr_cond & ~wr_cond_q;
  assign rd_rise = rd_cond & ~rd_cond_q;

  always_comb begin
    st_d      = st_q;
    ret_d     = ret_q;
    cnt_d     = cnt_q;
    cmd_d     = CmdNop;
    a_d       = a_q;
    dq_oe_d   = 1'b0;
    dq_out_d  = dq_out_q;
    rdata_d   = rdata_q;
    op_addr_d = op_addr_q;
    op_data_d = op_data_q;
    ref_clr   = 1'b0;
    wr_clr    = 1'b0;
    rd_clr    = 1'b0;
    case (st_q)
      StInitWait: begin
        if (cnt_q == 16'd0) st_d = StInitPre;
        else cnt_d = cnt_q - 16'd1;
      end
      StInitPre: begin
        cmd_d = CmdPre;
        a_d   = 12'h400;
        st_d  = StWait;
        cnt_d = 16'(T_RP - 2);
        ret_d = StInitRef1;
      end
      StInitRef1, StInitRef2: begin
        cmd_d = CmdRef;
        st_d  = StWait;
        cnt_d = 16'(T_RC - 2);
        ret_d = (st_q == StInitRef1) ? StInitRef2 : StInitMrs;
      end
      StInitMrs: begin
        cmd_d = CmdLmr;
        a_d   = 12'b00_0_00_010_0_000;
        st_d  = StWait;
        cnt_d = 16'(T_MRD - 2);
        ret_d = StIdle;
      end
      // cnt_q = T-2 on entry makes the next command land exactly T cycles after the last one
      StWait: begin
        if (cnt_q == 16'd0) st_d = ret_q;
        else cnt_d = cnt_q - 16'd1;
      end
      StIdle: begin
        if (ref_pend_q) begin
          cmd_d   = CmdRef;
          ref_clr = 1'b1;
          st_d    = StWait;
          cnt_d   = 16'(T_RC - 2);
          ret_d   = StIdle;
        end else if (wr_pend_q || rd_pend_q) begin
          cmd_d     = CmdAct;
          op_addr_d = wr_pend_q ? wr_addr_q : rd_addr_q;
          op_data_d = wr_data_q;
          a_d       = {4'b0000, op_addr_d[15:8]};
          wr_clr    = wr_pend_q;
          rd_clr    = ~wr_pend_q;
          st_d      = StWait;
          cnt_d     = 16'(T_RCD - 2);
          ret_d     = wr_pend_q ? StWr : StRd;
        end
      end
      StWr: begin
        cmd_d    = CmdWrit;
        a_d      = {4'b0100, op_addr_q[7:0]};
        dq_oe_d  = 1'b1;
        dq_out_d = op_data_q;
        st_d     = StWait;
        cnt_d    = 16'(T_WRAP - 2);
        ret_d    = StIdle;
      end
      StRd: begin
        cmd_d = CmdRead;
        a_d   = {4'b0100, op_addr_q[7:0]};
        st_d  = StWait;
        cnt_d = 16'(CAS_LAT - 1);
        ret_d = StRdCap;
      end
      StRdCap: begin
        rdata_d = sdr_dq;
        st_d    = StWait;
        cnt_d   = 16'(T_RP - 2);
        ret_d   = StIdle;
      end
      default: st_d = StInitWait;
    endcase
  end

  // Refresh timer is held at reload until init completes (led high)
  always_comb begin
    ref_cnt_d  = ref_cnt_q - 16'd1;
    ref_pend_d = ref_pend_q & ~ref_clr;
    if (!led_q) begin
      ref_cnt_d  = 16'(REFRESH_CYCLES);
      ref_pend_d = 1'b0;
    end else if (ref_cnt_q == 16'd1) begin
      ref_cnt_d  = 16'(REFRESH_CYCLES);
      ref_pend_d = 1'b1;
    end
    wr_pend_d = (wr_pend_q & ~wr_clr) | wr_rise;
    rd_pend_d = (rd_pend_q & ~rd_clr) | rd_rise;
    led_d     = led_q | (st_d == StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= StInitWait;
      ret_q      <= StIdle;
      cnt_q      <= 16'(INIT_CYCLES - 1);
      ref_cnt_q  <= 16'(REFRESH_CYCLES);
      ref_pend_q <= 1'b0;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      wr_addr_q  <= 16'h0000;
      wr_data_q  <= 16'h0000;
      rd_addr_q  <= 16'h0000;
      op_addr_q  <= 16'h0000;
      op_data_q  <= 16'h0000;
      rdata_q    <= 16'h0000;
      dq_out_q   <= 16'h0000;
      cmd_q      <= CmdNop;
      a_q        <= 12'h000;
      dq_oe_q    <= 1'b0;
      led_q      <= 1'b0;
      sync1_q    <= 3'b111;
      sync2_q    <= 3'b111;
      wr_cond_q  <= 1'b0;
      rd_cond_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      ret_q      <= ret_d;
      cnt_q      <= cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      wr_pend_q  <= wr_pend_d;
      rd_pend_q  <= rd_pend_d;
      op_addr_q  <= op_addr_d;
      op_data_q  <= op_data_d;
      rdata_q    <= rdata_d;
      dq_out_q   <= dq_out_d;
      cmd_q      <= cmd_d;
      a_q        <= a_d;
      dq_oe_q    <= dq_oe_d;
      led_q      <= led_d;
      sync1_q    <= {fsmc_ne1, fsmc_nwe, fsmc_noe};
      sync2_q    <= sync1_q;
      wr_cond_q  <= wr_cond;
      rd_cond_q  <= rd_cond;
      if (wr_rise) begin
        wr_addr_q <= fsmc_a;
        wr_data_q <= fsmc_d;
      end
      if (rd_rise) rd_addr_q <= fsmc_a;
    end
  end

  assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_q;
  assign sdr_clk = ~clk;
  assign sdr_cke = 1'b1;
  assign sdr_ba  = 2'b00;
  assign sdr_a   = a_q;
  assign sdr_dm  = 2'b00;
  assign led     = led_q;
  assign sdr_dq  = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign fsmc_d  = (!fsmc_ne1 && !fsmc_noe && fsmc_nwe) ? rdata_q : 16'hzzzz;

endmodule

// File: tb/tb_system.sv
// Bench for the FSMC-to-SDRAM bridge: SDRAM command logger with a small memory model,
// init/refresh checks, table-driven FSMC accesses and a reset-abort sequence.
module tb_system;
  localparam int INIT_CYCLES = 5000;
  localparam int REFRESH_CYCLES = 390;
  localparam int T_RP = 2;
  localparam int T_RC = 4;
  localparam logic [3:0] CNop = 4'b0111, CAct = 4'b0011, CRd = 4'b0101, CWr = 4'b0100;
  localparam logic [3:0] CPre = 4'b0010, CRef = 4'b0001, CLmr = 4'b0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  logic        led, fsmc_ne1, fsmc_nwe, fsmc_noe, fsmc_nbl1, fsmc_nbl0;
  logic [15:0] fsmc_a;
  wire  [15:0] fsmc_d, sdr_dq;
  logic        sdr_clk, sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
  logic [1:0]  sdr_ba, sdr_dm;
  logic [11:0] sdr_a;

  logic [15:0] tb_fd = 16'h0000;
  logic        tb_fd_oe = 1'b0;
  logic [15:0] mdl_dq = 16'h0000;
  logic        mdl_oe = 1'b0;
  assign fsmc_d = tb_fd_oe ? tb_fd : 16'hzzzz;
  assign sdr_dq = mdl_oe ? mdl_dq : 16'hzzzz;

  system dut (
    .clk(clk), .rst(rst), .led(led),
    .fsmc_a(fsmc_a), .fsmc_d(fsmc_d), .fsmc_ne1(fsmc_ne1), .fsmc_nwe(fsmc_nwe),
    .fsmc_noe(fsmc_noe), .fsmc_nbl1(fsmc_nbl1), .fsmc_nbl0(fsmc_nbl0),
    .sdr_clk(sdr_clk), .sdr_cke(sdr_cke), .sdr_cs_n(sdr_cs_n), .sdr_ras_n(sdr_ras_n),
    .sdr_cas_n(sdr_cas_n), .sdr_we_n(sdr_we_n), .sdr_ba(sdr_ba), .sdr_a(sdr_a),
    .sdr_dm(sdr_dm), .sdr_dq(sdr_dq)
  );

  typedef struct {
    int          cyc;
    logic [3:0]  cmd;
    logic [11:0] a;
    logic [1:0]  ba;
    logic [15:0] dq;
    logic [1:0]  dm;
  } cmd_t;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
    int          hold;
    logic [11:0] row;
    logic [11:0] col;
  } vec_t;

  cmd_t        log_q[$];
  logic [15:0] mem [logic [19:0]];
  int          cyc = 0;
  int          rd_cnt = 0;
  logic [11:0] open_row = 12'h000;
  logic [3:0]  mon_cmd;
  cmd_t        mon_e;
  int          n_chk = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // SDRAM model: sees commands on the sdr_clk rising edge, returns read data CL=2 later
  always @(negedge clk) begin
    if (rd_cnt != 0) begin
      rd_cnt = rd_cnt - 1;
      mdl_oe = (rd_cnt == 0);
    end else begin
      mdl_oe = 1'b0;
    end
    mon_cmd = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};
    if (mon_cmd !== CNop) begin
      mon_e.cyc = cyc; mon_e.cmd = mon_cmd; mon_e.a = sdr_a;
      mon_e.ba = sdr_ba; mon_e.dq = sdr_dq; mon_e.dm = sdr_dm;
      log_q.push_back(mon_e);
    end
    if (mon_cmd === CAct) open_row = sdr_a;
    if (mon_cmd === CWr) mem[{open_row, sdr_a[7:0]}] = sdr_dq;
    if (mon_cmd === CRd) begin
      mdl_dq = mem.exists({open_row, sdr_a[7:0]}) ? mem[{open_row, sdr_a[7:0]}] : 16'h5A5A;
      rd_cnt = 2;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic cmd_t log_at(input int i);
    cmd_t e;
    e.cyc = 0; e.cmd = 4'bxxxx; e.a = 'x; e.ba = 'x; e.dq = 'x; e.dm = 'x;
    if (i < log_q.size()) e = log_q[i];
    return e;
  endfunction

  task automatic chk_reset(input string nm);
    chk({nm, "_led"}, led, 0);
    chk({nm, "_cmd"}, {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n}, CNop);
    chk({nm, "_cke"}, sdr_cke, 1);
    chk({nm, "_ba_a"}, {sdr_ba, sdr_a}, 0);
    chk({nm, "_sdr_dq"}, sdr_dq, 16'hzzzz);
    chk({nm, "_fsmc_d"}, fsmc_d, 16'hzzzz);
  endtask

  task automatic wait_led(input string nm);
    int n = 0;
    while (led !== 1'b1 && n < INIT_CYCLES + 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, led, 1);
  endtask

  task automatic chk_init_seq(input string nm, input int rel);
    cmd_t e0, e1, e2, e3;
    e0 = log_at(0); e1 = log_at(1); e2 = log_at(2); e3 = log_at(3);
    chk({nm, "_pre"}, {e0.cmd, e0.a[10]}, {CPre, 1'b1});
    chk({nm, "_pre_after_wait"}, (e0.cyc - rel) >= INIT_CYCLES, 1);
    chk({nm, "_ref1"}, e1.cmd, CRef);
    chk({nm, "_ref2"}, e2.cmd, CRef);
    chk({nm, "_lmr"}, {e3.cmd, e3.a}, {CLmr, 12'h020});
    chk({nm, "_gaps"}, {e1.cyc - e0.cyc, e2.cyc - e1.cyc, e3.cyc - e2.cyc},
        {T_RP, T_RC, T_RC});
  endtask

  task automatic fsmc_write(input logic [15:0] a, input logic [15:0] d, input int hold);
    fsmc_a = a; tb_fd = d; tb_fd_oe = 1'b1;
    fsmc_ne1 = 1'b0; fsmc_nwe = 1'b0;
    repeat (hold) @(posedge clk);
    #1 fsmc_ne1 = 1'b1; fsmc_nwe = 1'b1;
    @(posedge clk); #1 tb_fd_oe = 1'b0;
  endtask

  task automatic fsmc_read(input string nm, input logic [15:0] a, input logic [15:0] exp);
    int n = 0;
    int bad = 0;
    fsmc_a = a; fsmc_nwe = 1'b1; fsmc_ne1 = 1'b0; fsmc_noe = 1'b0;
    while (fsmc_d !== exp && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_data"}, fsmc_d, exp);
    repeat (20) begin
      @(negedge clk);
      if (fsmc_d !== exp) bad++;
    end
    chk({nm, "_held"}, bad, 0);
    fsmc_ne1 = 1'b1; fsmc_noe = 1'b1;
    #1 chk({nm, "_release"}, fsmc_d, 16'hzzzz);
  endtask

  task automatic chk_access(input string nm, input vec_t v);
    int n_act = 0, n_op = 0, n_oth = 0;
    logic [11:0] act_a = 'x;
    cmd_t op;
    logic [3:0] opc;
    opc = v.wr ? CWr : CRd;
    op = log_at(-1);
    foreach (log_q[i]) begin
      if (log_q[i].cmd === CAct) begin n_act++; act_a = log_q[i].a; end
      else if (log_q[i].cmd === opc) begin n_op++; op = log_q[i]; end
      else if (log_q[i].cmd !== CRef) n_oth++;
    end
    chk({nm, "_counts"}, {n_act, n_op, n_oth}, {32'd1, 32'd1, 32'd0});
    chk({nm, "_row"}, act_a, v.row);
    chk({nm, "_col_ba"}, {op.ba, op.a}, {2'b00, v.col});
    if (v.wr) chk({nm, "_wdata"}, {op.dm, op.dq}, {2'b00, v.data});
  endtask

  vec_t vecs[8];

  initial begin
    int rel, n_ref, n_oth, bad_gap, n_act;
    cmd_t prev;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, n_ref, n_oth, bad_gap, n_act;
    vecs[0] = '{1'b1, 16'hAAAA, 16'hBBBB, 2500, 12'h0AA, 12'h4AA};
    vecs[1] = '{1'b1, 16'hCCCC, 16'hDDDD, 40, 12'h0CC, 12'h4CC};
    vecs[2] = '{1'b0, 16'hCCCC, 16'hDDDD, 0, 12'h0CC, 12'h4CC};
    vecs[3] = '{1'b0, 16'h1000, 16'h5A5A, 0, 12'h010, 12'h400};
    vecs[4] = '{1'b1, 16'h1234, 16'h5678, 40, 12'h012, 12'h434};
    vecs[5] = '{1'b0, 16'h1234, 16'h5678, 0, 12'h012, 12'h434};
    vecs[6] = '{1'b0, 16'h2222, 16'h3333, 0, 12'h022, 12'h422};
    vecs[7] = '{1'b0, 16'hAAAA, 16'hBBBB, 0, 12'h0AA, 12'h4AA};

    fsmc_a = 16'h0000; fsmc_ne1 = 1'b1; fsmc_nwe = 1'b1; fsmc_noe = 1'b1;
    fsmc_nbl1 = 1'b0; fsmc_nbl0 = 1'b0;

    #5 rst = 1'b1;
    #30 chk_reset("reset");
    @(posedge clk); #1 rst = 1'b0;
    rel = cyc;
    log_q.delete();

    // A write issued during the power-up wait must stay pending until init is done
    repeat (100) @(posedge clk);
    #1 fsmc_write(16'h2222, 16'h3333, 20);
    repeat (4600) @(posedge clk);
    #1 chk("led_during_init", led, 0);
    chk("no_cmd_during_init", log_q.size(), 0);
    wait_led("led_after_init");
    repeat (30) @(posedge clk);
    #1 chk_init_seq("init", rel);
    chk("init_pending_act", {log_at(4).cmd, log_at(4).a}, {CAct, 12'h022});
    chk("init_pending_wr", {log_at(5).cmd, log_at(5).a, log_at(5).dq},
        {CWr, 12'h422, 16'h3333});

    // Idle: only auto-refresh, at a fixed interval
    log_q.delete();
    repeat (1300) @(posedge clk);
    #1 n_ref = 0; n_oth = 0; bad_gap = 0;
    foreach (log_q[i]) begin
      if (log_q[i].cmd === CRef) n_ref++;
      else n_oth++;
      if (i > 0 && (log_q[i].cyc - log_q[i-1].cyc) != REFRESH_CYCLES) bad_gap++;
    end
    chk("idle_refresh_count", n_ref >= 3, 1);
    chk("idle_other_cmds", n_oth, 0);
    chk("idle_refresh_gap", bad_gap, 0);

    foreach (vecs[i]) begin
      log_q.delete();
      if (vecs[i].wr) fsmc_write(vecs[i].addr, vecs[i].data, vecs[i].hold);
      else fsmc_read($sformatf("v%0d", i), vecs[i].addr, vecs[i].data);
      repeat (20) @(posedge clk);
      #1 chk_access($sformatf("v%0d", i), vecs[i]);
    end

    // Reset while a write is pending but not yet issued
    log_q.delete();
    @(posedge clk);
    #1 fsmc_a = 16'h7777; tb_fd = 16'h1111; tb_fd_oe = 1'b1;
    fsmc_ne1 = 1'b0; fsmc_nwe = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    fsmc_ne1 = 1'b1; fsmc_nwe = 1'b1; tb_fd_oe = 1'b0;
    #1 chk_reset("abort");
    n_act = 0;
    foreach (log_q[i]) if (log_q[i].cmd === CAct || log_q[i].cmd === CWr) n_act++;
    chk("abort_not_yet_issued", n_act, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rel = cyc;
    log_q.delete();
    wait_led("abort_led_after_init");
    repeat (30) @(posedge clk);
    #1 chk_init_seq("reinit", rel);
    n_act = 0;
    foreach (log_q[i]) if (log_q[i].cmd === CAct || log_q[i].cmd === CWr) n_act++;
    chk("abort_write_dropped", n_act, 0);
    fsmc_read("abort_readback", 16'h7777, 16'h5A5A);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
